mem_access_sequencer: RTL

- Parametrised memory-stage access sequencer for the LC-3b pipeline, generalising the single/double-access (LDR/STR vs LDI/STI) controller to any access count up to MAX_ACCESSES per instruction.
- Issues accesses back to back and pulses an intermediate-data latch enable between them.
- Releases the memory stage with `proceed` on the final `mem_resp`.
- Adds flush abort, an illegal-count fault and a response watchdog.

---
 rtl/mem_access_sequencer_if.sv | 30 +++
 rtl/mem_access_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if: memory-stage handshake bundle.
// master = pipeline/memory side (drives start..mem_resp); slave = sequencer.
interface mem_access_sequencer_if #(
  parameter int CNT_W = 2
);
  logic             start;
  logic [CNT_W-1:0] num_accesses;
  logic             last_is_write;
  logic             abort;
  logic             mem_resp;
  logic             mem_read;
  logic             mem_write;
  logic [CNT_W-1:0] access_idx;
  logic             data_latch_en;
  logic             proceed;
  logic             busy;
  logic             fault;

  modport master (
    output start, num_accesses, last_is_write, abort, mem_resp,
    input  mem_read, mem_write, access_idx, data_latch_en,
    input  proceed, busy, fault
  );

  modport slave (
    input  start, num_accesses, last_is_write, abort, mem_resp,
    output mem_read, mem_write, access_idx, data_latch_en,
    output proceed, busy, fault
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: issues 1..MAX_ACCESSES memory accesses per instr.
// Ports: clk, reset_n (sync, active-low), bus (slave modport of the if).
module mem_access_sequencer #(
  parameter int MAX_ACCESSES = 2,
  parameter int CNT_W        = 2,
  parameter int TIMEOUT      = 0,
  parameter int TO_W         = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  mem_access_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    FAULT
  } state_e;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ACCESSES);
  localparam logic [TO_W-1:0]  TO_C  = TO_W'(TIMEOUT);
  localparam bit               WD_EN = (TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  wd_q, wd_d;

  logic             act;
  logic             last;
  logic             rd, wr, dle, prc, bsy, flt;

  // last: current access is the final one of this instruction
  assign last = (idx_q == bus.num_accesses - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    act     = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    dle     = 1'b0;
    prc     = 1'b0;
    bsy     = 1'b0;
    flt     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_accesses == '0) begin
            prc = 1'b1;
          end else if (bus.num_accesses > MAX_C) begin
            state_d = FAULT;
          end else begin
            // zero-latency issue: idx_q is 0 whenever IDLE
            act = 1'b1;
          end
        end
      end
      ACCESS: act = 1'b1;
      FAULT:  flt = 1'b1;
      default: state_d = IDLE;
    endcase

    if (act) begin
      bsy = 1'b1;
      wr  = bus.last_is_write && last;
      rd  = !wr;
      if (bus.mem_resp) begin
        wd_d = '0;
        if (last) begin
          prc     = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          dle     = 1'b1;
          idx_d   = idx_q + CNT_W'(1);
          state_d = ACCESS;
        end
      end else begin
        if (wd_q != '1) wd_d = wd_q + TO_W'(1);
        if (WD_EN && wd_q == TO_C) state_d = FAULT;
        else                       state_d = ACCESS;
      end
    end

    // flush: request lines stay as-is, completions are suppressed
    if (bus.abort) begin
      prc     = 1'b0;
      dle     = 1'b0;
      idx_d   = '0;
      wd_d    = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.mem_read      = rd;
  assign bus.mem_write     = wr;
  assign bus.access_idx    = idx_q;
  assign bus.data_latch_en = dle;
  assign bus.proceed       = prc;
  assign bus.busy          = bsy;
  assign bus.fault         = flt;

endmodule
